// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: streams sequential words from instruction memory ahead of the
// core's PC and flushes/restarts on any PC discontinuity.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_INC   = 1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        consume,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);
    localparam logic [31:0] Inc = 32'(PC_INC);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e          state_q, state_d;
    logic [31:0]     exp_pc_q, exp_pc_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [31:0]     drop_addr_q, drop_addr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]     mem_q [DEPTH];

    logic redirect;
    logic pop;
    logic push;

    assign redirect = (pc_in != exp_pc_q);
    assign pop      = consume && instr_valid;
    assign push     = (state_q == StReq) && imem_ack && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            exp_pc_q     <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            exp_pc_q     <= exp_pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_addr_q  <= drop_addr_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Buffer bookkeeping; a redirect flushes and suppresses both push and pop.
    always_comb begin
        exp_pc_d     = exp_pc_q;
        fetch_addr_d = fetch_addr_q;
        drop_addr_d  = drop_addr_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        if (redirect) begin
            count_d      = '0;
            rd_ptr_d     = wr_ptr_q;
            exp_pc_d     = pc_in;
            fetch_addr_d = pc_in;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                exp_pc_d = exp_pc_q + Inc;
            end
            if (push) begin
                wr_ptr_d     = wr_ptr_q + PtrW'(1);
                fetch_addr_d = fetch_addr_q + Inc;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
        // The squashed request must stay on the bus at its original address until acked.
        if ((state_q == StReq) && !imem_ack && redirect) begin
            drop_addr_d = fetch_addr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (redirect || (count_q < Full)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (imem_ack) begin
                    if (redirect) begin
                        state_d = StReq;
                    end else begin
                        state_d = (count_d < Full) ? StReq : StIdle;
                    end
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_ack) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req    = (state_q != StIdle);
        imem_addr   = (state_q == StDrop) ? drop_addr_q : fetch_addr_q;
        instr_valid = !redirect && (count_q != '0);
        instruction = instr_valid ? mem_q[rd_ptr_q] : 32'h0;
    end

endmodule
